// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtraction controller.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-position counter width; one extra bit keeps WIDTH=64 from wrapping.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/fs_bit.sv
// One-bit full subtractor built from two half-subtract stages plus an OR.
module fs_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  // First half-subtract x - y, second subtracts the incoming borrow.
  always_comb begin
    d1   = x ^ y;
    b1   = ~x & y;
    d    = d1 ^ bin;
    b2   = ~d1 & bin;
    bout = b1 | b2;
  end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    count;
  logic             borrow;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             d;
  logic             bnext;

  fs_bit u_fs_bit (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (borrow),
    .d    (d),
    .bout (bnext)
  );

  // Result register shifts right with the new difference bit entering at the MSB.
  // Written as shift-then-overwrite so WIDTH=1 needs no special slice.
  always_comb begin
    res_next            = res_sr >> 1;
    res_next[WIDTH-1]   = d;
  end

  // Controller FSM, counter, shift registers and registered outputs.
  // diff/borrow_out load only on RUN completion so they hold across the next operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      borrow     <= 1'b0;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      ready      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            borrow <= 1'b0;
            count  <= '0;
            ready  <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          borrow <= bnext;
          count  <= count + CW'(1);
          if (count == LAST) begin
            diff       <= res_next;
            borrow_out <= bnext;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl at WIDTH=8, 13 and 1.
module tb_serial_sub_ctrl;

  typedef struct {
    logic [63:0] d;
    logic        bo;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start8 = 0, start13 = 0, start1 = 0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [12:0] a13 = '0, b13 = '0;
  logic [0:0]  a1 = '0, b1 = '0;
  logic        ready8, busy8, done8, bo8;
  logic        ready13, busy13, done13, bo13;
  logic        ready1, busy1, done1, bo1;
  logic [7:0]  diff8;
  logic [12:0] diff13;
  logic [0:0]  diff1;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8));
  serial_sub_ctrl #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13),
    .ready(ready13), .busy(busy13), .done(done13), .diff(diff13), .borrow_out(bo13));
  serial_sub_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .ready(ready1), .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1));

  exp_t q8[$], q13[$], q1[$];
  int   done_t8[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return ready8;
      1:       return ready13;
      default: return ready1;
    endcase
  endfunction

  function automatic logic bsy(input int sel);
    case (sel)
      0:       return busy8;
      1:       return busy13;
      default: return busy1;
    endcase
  endfunction

  function automatic logic dn(input int sel);
    case (sel)
      0:       return done8;
      1:       return done13;
      default: return done1;
    endcase
  endfunction

  task automatic drive(input int sel, input logic s, input logic [63:0] av, input logic [63:0] bv);
    case (sel)
      0:       begin start8  = s; a8  = av[7:0];  b8  = bv[7:0];  end
      1:       begin start13 = s; a13 = av[12:0]; b13 = bv[12:0]; end
      default: begin start1  = s; a1  = av[0:0];  b1  = bv[0:0];  end
    endcase
  endtask

  // Reference model: modulo difference and borrow as plain integer arithmetic.
  function automatic exp_t model(input int w, input logic [63:0] av, input logic [63:0] bv);
    exp_t        e;
    logic [63:0] mask;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    e.d  = (av - bv) & mask;
    e.bo = ((av & mask) < (bv & mask));
    return e;
  endfunction

  task automatic push(input int sel, input exp_t e);
    case (sel)
      0:       q8.push_back(e);
      1:       q13.push_back(e);
      default: q1.push_back(e);
    endcase
  endtask

  // Scoreboard monitors: every done pulse must match the oldest expected result.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done8) begin
      done_t8.push_back(cyc);
      if (q8.size() == 0) check("sb8_spurious_done", 1, 0);
      else begin
        e = q8.pop_front();
        check("sb8_diff", {56'd0, diff8}, e.d);
        check("sb8_borrow", {63'd0, bo8}, {63'd0, e.bo});
      end
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done13) begin
      if (q13.size() == 0) check("sb13_spurious_done", 1, 0);
      else begin
        e = q13.pop_front();
        check("sb13_diff", {51'd0, diff13}, e.d);
        check("sb13_borrow", {63'd0, bo13}, {63'd0, e.bo});
      end
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done1) begin
      if (q1.size() == 0) check("sb1_spurious_done", 1, 0);
      else begin
        e = q1.pop_front();
        check("sb1_diff", {63'd0, diff1}, e.d);
        check("sb1_borrow", {63'd0, bo1}, {63'd0, e.bo});
      end
    end
  end

  // One operation: start pulse, a/b scrambled after acceptance, measures done latency
  // (edges after the accepting edge) and number of samples with ready low.
  task automatic run_op(input int sel, input int w, input logic [63:0] av, input logic [63:0] bv,
                        output int lat, output int nlow);
    int t;
    t = 0;
    while (!rdy(sel) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!rdy(sel)) check("wait_ready_timeout", 0, 1);
    @(negedge clk);
    drive(sel, 1'b1, av, bv);
    push(sel, model(w, av, bv));
    @(posedge clk);
    #1;
    check("accept_ready_low", {63'd0, rdy(sel)}, 0);
    check("accept_busy_high", {63'd0, bsy(sel)}, 1);
    nlow = 1;
    lat  = -1;
    @(negedge clk);
    drive(sel, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
    for (int k = 1; k <= w + 10; k++) begin
      @(posedge clk);
      #1;
      if (!rdy(sel)) nlow++;
      if (dn(sel)) lat = k;
      if (rdy(sel)) break;
    end
    if (!rdy(sel)) check("op_timeout", 0, 1);
  endtask

  initial begin
    int          lat, nlow, dones;
    logic [7:0]  hold_d;
    logic        hold_b;
    logic [63:0] ra, rb;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {63'd0, ready8}, 1);
    check("rst_busy", {63'd0, busy8}, 0);
    check("rst_done", {63'd0, done8}, 0);
    check("rst_diff", {56'd0, diff8}, 0);
    check("rst_borrow", {63'd0, bo8}, 0);
    check("rst_ready13", {63'd0, ready13}, 1);
    check("rst_ready1", {63'd0, ready1}, 1);
    @(negedge clk);
    rst = 1'b0;

    // Basic operation and latency at WIDTH=8
    run_op(0, 8, 64'd100, 64'd37, lat, nlow);
    check("lat_w8", lat, 8);
    check("ready_low_w8", nlow, 9);

    // Borrow and boundary patterns
    run_op(0, 8, 64'd0, 64'd0, lat, nlow);
    run_op(0, 8, 64'h00, 64'h01, lat, nlow);
    run_op(0, 8, 64'hFF, 64'h00, lat, nlow);
    run_op(0, 8, 64'd5, 64'd9, lat, nlow);

    // Hold: outputs stable and no done while idle
    hold_d = diff8;
    hold_b = bo8;
    check("hold_diff_value", {56'd0, hold_d}, 64'hFC);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("hold_diff", {56'd0, diff8}, {56'd0, hold_d});
      check("hold_borrow", {63'd0, bo8}, {63'd0, hold_b});
      check("hold_done", {63'd0, done8}, 0);
    end

    // start held high: one op per WIDTH+2 cycles, a/b changing every cycle
    done_t8.delete();
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      a8 = ra[7:0];
      b8 = rb[7:0];
      start8 = 1'b1;
      if (ready8) q8.push_back(model(8, ra, rb));
    end
    @(negedge clk);
    start8 = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("held_start_ops", {63'd0, done_t8.size() >= 3}, 1);
    for (int i = 1; i < done_t8.size(); i++)
      check("held_start_period", done_t8[i] - done_t8[i-1], 10);

    // Reset in mid-RUN aborts with no done pulse
    @(negedge clk);
    drive(0, 1'b1, 64'd200, 64'd3);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 64'd0, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ready", {63'd0, ready8}, 1);
    check("abort_busy", {63'd0, busy8}, 0);
    check("abort_diff", {56'd0, diff8}, 0);
    check("abort_borrow", {63'd0, bo8}, 0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done8) dones++;
    end
    check("abort_no_done", dones, 0);
    run_op(0, 8, 64'd77, 64'd78, lat, nlow);
    check("after_abort_lat", lat, 8);

    // WIDTH=1, all four combinations
    for (int i = 0; i < 4; i++) begin
      run_op(2, 1, 64'(i >> 1), 64'(i & 1), lat, nlow);
      check("lat_w1", lat, 1);
    end

    // Random sweeps at WIDTH=8 and WIDTH=13
    for (int i = 0; i < 20; i++) begin
      run_op(0, 8, {$urandom, $urandom}, {$urandom, $urandom}, lat, nlow);
      run_op(1, 13, {$urandom, $urandom}, {$urandom, $urandom}, lat, nlow);
      check("lat_w13", lat, 13);
    end
    run_op(1, 13, 64'h0, 64'h1FFF, lat, nlow);

    repeat (5) @(posedge clk);
    #2;
    check("sb8_empty", q8.size(), 0);
    check("sb13_empty", q13.size(), 0);
    check("sb1_empty", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
